seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/sat_counter.sv | 21 ++
 rtl/seq_detector_param.sv | 71 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Holds default pattern, overlap mode codes and the fill-width function.
package seq_det_pkg;

  localparam int PAT_W_MAX = 16;

  localparam logic [3:0] PAT_INIT_DEF = 4'b1011;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Width needed to hold a fill count of 0..n-1 (at least one bit).
  function automatic int fill_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear wins).
// Ports: clk, rst, clr, inc, q[W].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with Mealy match flag and optional match counter.
// Ports: clk, rst, d, d_en, overlap, pat_load, pat_in, cnt_clr, out, match_cnt.
// Counter built only when SEQ_DETECTOR_COUNT_EN is defined.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF),
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             d_en,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = fill_w(PAT_W);
  localparam int HW = PAT_W - 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q;
  logic [HW-1:0]    hist_q;
  logic [FW-1:0]    fill_q;
  logic             hit;

  // fill_q counts valid history bits; a match needs a full history.
  assign hit = (fill_q == FILL_MAX) && ({hist_q, d} == pat_q);
  assign out = d_en & ~rst & ~pat_load & hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      fill_q <= '0;
    end else if (d_en) begin
      // Truncating cast drops the oldest bit.
      hist_q <= HW'({hist_q, d});
      if (out && (overlap != MODE_OVL)) begin
        fill_q <= '0;
      end else if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (out),
    .q   (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule
